// File: rtl/d_input_debouncer_if.sv
// Bundles the conditioned input, enable and debounced outputs of
// d_input_debouncer. The glitch counter signals exist only when
// DEBOUNCE_GLITCH_CNT_EN is defined.
interface d_input_debouncer_if
`ifdef DEBOUNCE_GLITCH_CNT_EN
  #(parameter int GLITCH_W = 8)
`endif
  ();

  logic din;
  logic en;
  logic d;
  logic db;
  logic rise;
  logic fall;
  logic stable;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                glitch_clr;
  logic [GLITCH_W-1:0] glitch_cnt;
`endif

  // Driver side: supplies the raw input and enable, observes the clean level
  modport master (
    output din, en,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output glitch_clr,
    input  glitch_cnt,
`endif
    input  d, db, rise, fall, stable
  );

  // Debouncer side
  modport slave (
    input  din, en,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    input  glitch_clr,
    output glitch_cnt,
`endif
    output d, db, rise, fall, stable
  );

endinterface

// File: rtl/d_input_debouncer.sv
// Input conditioner ahead of d_ff: synchronizes a raw asynchronous input,
// qualifies a level change over DEBOUNCE_CYCLES consecutive enabled samples,
// and emits a clean level, its complement and one-cycle edge pulses.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating count of rejected
// transitions with a synchronous clear.
module d_input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int GLITCH_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  d_input_debouncer_if.slave    bus
);

  // Reject illegal parameter combinations while elaborating
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 || CNT_W < 1 ||
      GLITCH_W < 1 || (CNT_W < 31 && DEBOUNCE_CYCLES >= (1 << CNT_W))) begin : g_param_check
    $error("d_input_debouncer: illegal parameters SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d CNT_W=%0d GLITCH_W=%0d",
           SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W, GLITCH_W);
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_QUAL = 1'b1
  } state_t;

  // Count value at which the next differing sample is the final one needed
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a single-sample requirement a change commits straight from IDLE
  localparam bit               SINGLE_HIT = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_d;
  logic                   r_db;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_stable;

  logic w_s;
  logic w_diff;
  logic w_commit;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = bus.en && (w_s != r_d);
  // A commit happens on the last required differing sample, from either state
  assign w_commit = w_diff && ((r_state == ST_IDLE) ? SINGLE_HIT : (r_cnt == CNT_LAST));

  // Synchronizer chain: shifts every cycle regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.din};
    end
  end

  // Qualification FSM with registered level, complement, pulses and stable flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_d      <= 1'b0;
      r_db     <= 1'b1;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_stable <= 1'b1;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_commit) begin
        r_d      <= w_s;
        r_db     <= ~w_s;
        r_rise   <= w_s;
        r_fall   <= ~w_s;
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_stable <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_diff) begin
              r_state  <= ST_QUAL;
              r_cnt    <= CNT_W'(1);
              r_stable <= 1'b0;
            end
          end
          ST_QUAL: begin
            if (bus.en) begin
              if (w_s == r_d) begin
                // Input fell back to the committed level: reject the change
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_stable <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_stable <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.d      = r_d;
  assign bus.db     = r_db;
  assign bus.rise   = r_rise;
  assign bus.fall   = r_fall;
  assign bus.stable = r_stable;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch_cnt;
  logic                w_glitch;

  assign w_glitch = (r_state == ST_QUAL) && bus.en && (w_s == r_d);

  // Saturating rejected-transition counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (bus.glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign bus.glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_d_input_debouncer.sv
// Self-checking bench for d_input_debouncer: directed scenarios with literal
// expectations followed by randomized stimulus compared every cycle against a
// behavioural model (input delay by sample history, run length of enabled
// differing samples). Glitch counter checks apply when DEBOUNCE_GLITCH_CNT_EN
// is defined.
module tb_d_input_debouncer;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit hist[$];     // din value sampled at each edge since reset (most recent last)
  int run;         // consecutive enabled samples differing from the committed level
  bit m_d;
  bit m_rise;
  bit m_fall;
  int m_gc;
  int m_glitches;

  always #5 clk = ~clk;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  d_input_debouncer_if #(.GLITCH_W(GW)) bus ();
`else
  d_input_debouncer_if bus ();
`endif

  d_input_debouncer #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (8),
    .GLITCH_W        (GW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    run    = 0;
    m_d    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_gc   = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge
  task automatic model_edge();
    bit s;
    bit glitch;
    s      = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
    glitch = 1'b0;
    hist.push_back(bus.din);
    if (hist.size() > 8) void'(hist.pop_front());
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (bus.en) begin
      if (s != m_d) begin
        run++;
        if (run == DC) begin
          m_d    = s;
          m_rise = s;
          m_fall = !s;
          run    = 0;
        end
      end else begin
        glitch = (run > 0);
        run    = 0;
      end
    end
    if (glitch) m_glitches++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    if (bus.glitch_clr) m_gc = 0;
    else if (glitch && m_gc < (1 << GW) - 1) m_gc++;
`endif
  endtask

  task automatic compare_all();
    chk("d",      int'(bus.d),      int'(m_d));
    chk("db",     int'(bus.db),     int'(!m_d));
    chk("rise",   int'(bus.rise),   int'(m_rise));
    chk("fall",   int'(bus.fall),   int'(m_fall));
    chk("stable", int'(bus.stable), (run == 0) ? 1 : 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt", int'(bus.glitch_cnt), m_gc);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse(input int hold_cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (hold_cycles) cycle();
    rst_n = 1'b1;
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // From d=1: drop din for 3 sampled edges then restore; the rejection lands on edge 6
  task automatic glitch_burst(input bit clr_on_glitch);
    bus.din = 1'b0;
    repeat (3) cycle();
    bus.din = 1'b1;
    repeat (2) cycle();
    bus.glitch_clr = clr_on_glitch;
    cycle();
    bus.glitch_clr = 1'b0;
    repeat (2) cycle();
  endtask
`endif

  initial begin
    int hold;
    rst_n      = 1'b0;
    bus.din    = 1'b1;
    bus.en     = 1'b1;
    m_glitches = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    bus.glitch_clr = 1'b0;
`endif
    model_reset();

    // Reset held with din=1, en=1; d rises on edge 6 after release
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("rst_d", int'(bus.d), 0);
      chk("rst_db", int'(bus.db), 1);
      chk("rst_pulses", int'(bus.rise) + int'(bus.fall), 0);
      chk("rst_stable", int'(bus.stable), 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("rst_glitch_cnt", int'(bus.glitch_cnt), 0);
`endif
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 5) chk("release_d_e5", int'(bus.d), 0);
      if (i == 6) chk("release_d_e6", int'(bus.d), 1);
    end
    $display("[%0t] reset/release: d=%0d", $time, bus.d);

    // Committed fall: pulse on edge 6, cleared on edge 7
    bus.din = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i == 5) chk("fall_d_e5", int'(bus.d), 1);
      if (i == 6) begin
        chk("fall_d_e6", int'(bus.d), 0);
        chk("fall_pulse_e6", int'(bus.fall), 1);
      end
      if (i == 7) chk("fall_pulse_e7", int'(bus.fall), 0);
    end
    $display("[%0t] clean fall: d=%0d", $time, bus.d);

    // Clean rise: stable low on edges 3-5, commit on edge 6
    bus.din = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i <= 2) chk("rise_stable_pre", int'(bus.stable), 1);
      if (i >= 3 && i <= 5) chk("rise_stable_qual", int'(bus.stable), 0);
      if (i == 6) begin
        chk("rise_d_e6", int'(bus.d), 1);
        chk("rise_db_e6", int'(bus.db), 0);
        chk("rise_pulse_e6", int'(bus.rise), 1);
        chk("rise_stable_e6", int'(bus.stable), 1);
      end
      if (i == 7) chk("rise_pulse_e7", int'(bus.rise), 0);
    end
    $display("[%0t] clean rise: d=%0d", $time, bus.d);

    // Reset during qualification of a fall: d=0 at once, no pulse
    bus.din = 1'b0;
    repeat (4) cycle();
    chk("midq_stable", int'(bus.stable), 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midq_async_d", int'(bus.d), 0);
    chk("midq_async_fall", int'(bus.fall), 0);
    compare_all();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();
    $display("[%0t] reset mid-qualification: d=%0d", $time, bus.d);

    // Glitch: din high for 3 sampled edges only
    bus.din = 1'b1;
    repeat (3) cycle();
    bus.din = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      chk("glitch_d", int'(bus.d), 0);
      chk("glitch_rise", int'(bus.rise), 0);
    end
    chk("glitch_stable", int'(bus.stable), 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_one", int'(bus.glitch_cnt), 1);
`endif
    $display("[%0t] glitch rejected: d=%0d", $time, bus.d);

    // Enable stall after two counted samples
    bus.din = 1'b1;
    repeat (4) cycle();
    bus.en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("stall_d", int'(bus.d), 0);
      chk("stall_stable", int'(bus.stable), 0);
      chk("stall_rise", int'(bus.rise), 0);
    end
    bus.en = 1'b1;
    cycle();
    chk("stall_d_en1", int'(bus.d), 0);
    cycle();
    chk("stall_d_en2", int'(bus.d), 1);
    chk("stall_rise_en2", int'(bus.rise), 1);
    repeat (2) cycle();
    $display("[%0t] enable stall: d=%0d", $time, bus.d);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Saturation at 2**GW-1 and clear winning over a simultaneous glitch
    repeat (5) glitch_burst(1'b0);
    chk("glitch_cnt_sat", int'(bus.glitch_cnt), 3);
    glitch_burst(1'b1);
    chk("glitch_cnt_clr", int'(bus.glitch_cnt), 0);
    $display("[%0t] glitch saturation/clear: glitch_cnt=%0d", $time, bus.glitch_cnt);
`endif

    // Randomized phase against the model
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        bus.din = 1'($urandom_range(0, 1));
        hold    = $urandom_range(1, 8);
      end
      hold--;
      bus.en = ($urandom_range(0, 9) != 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      bus.glitch_clr = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 299) == 0) async_reset_pulse($urandom_range(1, 3));
      cycle();
    end
    $display("[%0t] random phase: glitches seen by model=%0d", $time, m_glitches);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
